// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, control encodings and address decoding for memory.
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BYTE_SLCT_W = 4;
  localparam logic [DATA_W-1:0] ZERO_WORD = 32'h0;
  localparam logic RST_ACTIVE = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  typedef struct packed {
    logic ok;
    logic [ADDR_W-3:0] idx;
  } word_loc_t;
  function automatic word_loc_t locate(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    word_loc_t l;
    l.idx = (ADDR_W-2)'(addr >> 2);
    l.ok = (addr >> 2) < ADDR_W'(depth);
    return l;
  endfunction
endpackage

// File: rtl/memory_if.sv
// memory_if: CPU fetch and load/store bus into the combined instruction/data memory.
interface memory_if;
  import mem_pkg::*;
  logic rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] inst;
  logic ce;
  logic we;
  logic [ADDR_W-1:0] addr_i;
  logic [BYTE_SLCT_W-1:0] byte_slct;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;
  modport master(output rom_ce, rom_addr, ce, we, addr_i, byte_slct, data_i, input inst, data_o);
  modport slave(input rom_ce, rom_addr, ce, we, addr_i, byte_slct, data_i, output inst, data_o);
endinterface

// File: rtl/memory_rom.sv
// rom: preloaded instruction words with combinational fetch; misses read as nop.
module rom import mem_pkg::*; #(
  parameter int DEPTH = 1024
) (
  input  logic              rst,
  input  logic              rom_ce,
  input  logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] inst
);
  localparam int RI = $clog2(DEPTH);
  logic [DATA_W-1:0] rom_data [0:DEPTH-1];
  word_loc_t loc;
  logic unused_idx;
  assign loc = locate(rom_addr, DEPTH);
  assign unused_idx = &{1'b0, loc.idx[ADDR_W-3:RI]};
  assign inst = (rst != RST_ACTIVE && rom_ce == CHIP_ENABLE && loc.ok) ? rom_data[loc.idx[RI-1:0]] : ZERO_WORD;
endmodule

// File: rtl/memory.sv
// memory: instruction ROM plus byte-maskable data RAM for the MIPS SOPC.
// Define MEM_WRITE_TRACE_EN to print every committed RAM write.
module memory import mem_pkg::*; #(
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_DEPTH = 1024
) (
  input logic      clk,
  input logic      rst,
  memory_if.slave  bus
);
  localparam int RI = $clog2(RAM_DEPTH);
  logic [DATA_W-1:0] ram [0:RAM_DEPTH-1];
  word_loc_t loc;
  logic [RI-1:0] idx;
  logic [DATA_W-1:0] mask, merged;
  logic wr_ok, unused_idx;
  rom #(.DEPTH(ROM_DEPTH)) ROM (
    .rst(rst),
    .rom_ce(bus.rom_ce),
    .rom_addr(bus.rom_addr),
    .inst(bus.inst)
  );
  assign loc = locate(bus.addr_i, RAM_DEPTH);
  assign idx = loc.idx[RI-1:0];
  assign unused_idx = &{1'b0, loc.idx[ADDR_W-3:RI]};
  always_comb begin
    mask = '0;
    for (int i = 0; i < BYTE_SLCT_W; i++) mask[8*i+:8] = {8{bus.byte_slct[i]}};
  end
  assign merged = (ram[idx] & ~mask) | (bus.data_i & mask);
  // rst is sampled at the edge, so a reset held across it cancels the write
  assign wr_ok = rst != RST_ACTIVE && bus.we == WRITE_ENABLE && loc.ok;
  assign bus.data_o = (rst != RST_ACTIVE && bus.ce == CHIP_ENABLE && bus.we != WRITE_ENABLE && loc.ok) ? ram[idx] : ZERO_WORD;
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      ram[idx] <= merged;
`ifdef MEM_WRITE_TRACE_EN
      $display("%0t mem write addr=%h slct=%b word=%h", $time, {bus.addr_i[ADDR_W-1:2], 2'b00}, bus.byte_slct, merged);
`endif
    end
  end
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed plus randomized checks of memory against an array-based model.
module tb_memory;
  localparam int DEPTH = 1024;
  localparam logic [31:0] SPAN = DEPTH * 4;
  logic clk = 0;
  logic rst = 0;
  int tests = 0;
  int fails = 0;
  logic [31:0] ram_m [0:DEPTH-1];
  logic [31:0] rom_m [0:DEPTH-1];
  memory_if bus();
  memory dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    return (rst && bus.ce && !bus.we && bus.addr_i < SPAN) ? ram_m[bus.addr_i / 4] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_inst();
    return (rst && bus.rom_ce && bus.rom_addr < SPAN) ? rom_m[bus.rom_addr / 4] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    if (rst && a < SPAN)
      for (int i = 0; i < 4; i++) if (sel[i]) ram_m[a / 4][8*i+:8] = d[8*i+:8];
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
    bus.ce = 0; bus.we = 1; bus.addr_i = a; bus.byte_slct = sel; bus.data_i = d;
    @(posedge clk); #1;
    model_write(a, sel, d);
    bus.we = 0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bus.ce = 1; bus.we = 0; bus.addr_i = a; #1;
    check(tag, bus.data_o, exp_data());
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    bus.rom_ce = 1; bus.rom_addr = a; #1;
    check(tag, bus.inst, exp_inst());
  endtask

  initial begin
    bus.rom_ce = 0; bus.rom_addr = 0; bus.ce = 0; bus.we = 0;
    bus.addr_i = 0; bus.byte_slct = 0; bus.data_i = 0;
    rom_m[0] = 32'h34011100; rom_m[1] = 32'h34020020; rom_m[2] = 32'h00000000;
    for (int i = 3; i < 16; i++) rom_m[i] = $urandom;
    rom_m[DEPTH-1] = $urandom;
    for (int i = 0; i < 16; i++) dut.ROM.rom_data[i] = rom_m[i];
    dut.ROM.rom_data[DEPTH-1] = rom_m[DEPTH-1];
    #2;
    bus.rom_ce = 1; bus.ce = 1; #1;
    check("inst_in_reset", bus.inst, 32'h0);
    check("data_in_reset", bus.data_o, 32'h0);
    @(posedge clk); #1;
    rst = 1;
    fetch("fetch_0", 0);
    check("fetch_0_const", bus.inst, 32'h34011100);
    fetch("fetch_4", 4);
    check("fetch_4_const", bus.inst, 32'h34020020);
    fetch("fetch_8", 8);
    fetch("fetch_unaligned", 2);
    check("fetch_unaligned_const", bus.inst, 32'h34011100);
    fetch("fetch_last", SPAN - 4);
    fetch("fetch_past_end", SPAN);
    check("fetch_past_end_zero", bus.inst, 32'h0);
    fetch("fetch_oor", 32'h4000_0000);
    bus.rom_ce = 0; #1;
    check("fetch_ce_off", bus.inst, 32'h0);
    wr(32'h10, 4'b1111, 32'hDEADBEEF);
    rd("load_full", 32'h10);
    check("load_full_const", bus.data_o, 32'hDEADBEEF);
    bus.ce = 0; #1;
    check("load_ce_off", bus.data_o, 32'h0);
    wr(32'h10, 4'b0100, 32'h00AA0000);
    wr(32'h12, 4'b0001, 32'h00000011);
    rd("byte_lanes", 32'h10);
    check("byte_lanes_const", bus.data_o, 32'hDEAABE11);
    wr(32'h10, 4'b0000, 32'hFFFFFFFF);
    rd("slct_none", 32'h10);
    check("slct_none_const", bus.data_o, 32'hDEAABE11);
    wr(32'h4000_0010, 4'b1111, 32'h12345678);
    rd("oor_no_alias", 32'h10);
    check("oor_no_alias_const", bus.data_o, 32'hDEAABE11);
    rd("oor_read", 32'h4000_0000);
    wr(SPAN, 4'b1111, 32'h12345678);
    rd("past_end_read", SPAN);
    wr(SPAN - 4, 4'b1111, 32'h0BADF00D);
    rd("last_word", SPAN - 4);
    check("last_word_const", bus.data_o, 32'h0BADF00D);
    rd("word0_untouched_by_past_end", 0);
    wr(32'h20, 4'b1111, 32'h01234567);
    bus.we = 1; bus.ce = 1; bus.addr_i = 32'h20; bus.byte_slct = 4'b1111;
    bus.data_i = 32'hCAFEBABE; bus.rom_ce = 1; bus.rom_addr = 0;
    rst = 0; #1;
    check("rst_data_zero", bus.data_o, 32'h0);
    check("rst_inst_zero", bus.inst, 32'h0);
    @(posedge clk); #1;
    check("rst_held_data", bus.data_o, 32'h0);
    check("rst_held_inst", bus.inst, 32'h0);
    rst = 1; bus.we = 0;
    rd("rst_cancel_write", 32'h20);
    check("rst_cancel_write_const", bus.data_o, 32'h01234567);
    bus.ce = 1; bus.we = 1; bus.addr_i = 32'h10; bus.byte_slct = 4'b1111; bus.data_i = 32'h11111111; #1;
    check("rw_same_cycle", bus.data_o, 32'h0);
    @(posedge clk); #1;
    model_write(32'h10, 4'b1111, 32'h11111111);
    bus.we = 0; #1;
    check("rw_next_cycle", bus.data_o, 32'h11111111);
    for (int i = 0; i < 16; i++) wr(i * 4, 4'b1111, $urandom);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (SPAN + $urandom_range(0, 255)) : $urandom_range(0, 63);
      bus.addr_i = a;
      bus.ce = $urandom_range(0, 3) != 0;
      bus.we = $urandom_range(0, 1);
      bus.byte_slct = $urandom;
      bus.data_i = $urandom;
      bus.rom_ce = $urandom_range(0, 3) != 0;
      bus.rom_addr = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom_range(0, 63);
      #1;
      check("rand_data", bus.data_o, exp_data());
      check("rand_inst", bus.inst, exp_inst());
      @(posedge clk); #1;
      if (bus.we) model_write(a, bus.byte_slct, bus.data_i);
    end
    bus.we = 0;
    for (int i = 0; i < 16; i++) rd("final_sweep", i * 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
